// File: rtl/md_unit_if.sv
// MD unit bus: EX-stage control/operands in, busy/done and HI/LO out.
interface md_unit_if;
  logic        md_valid;
  logic [2:0]  md_func;
  logic        md_sign;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_valid, md_func, md_sign, flush, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  md_valid, md_func, md_sign, flush, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module md_unit #(
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  md_unit_if.slave   bus
);

  localparam int unsigned CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_op_a;      // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0]        r_op_b;      // multiplier, or divisor magnitude
  logic [31:0]        r_rem;       // partial remainder
  logic               r_sign;      // signed multiply
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  logic               w_issue;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_prod;
  logic [32:0]        w_rem_sh;
  logic [32:0]        w_diff;
  logic               w_ge;
  logic [31:0]        w_quot;
  logic [31:0]        w_remd;

  // Issue qualification; busy is registered so this has no loop through outputs.
  assign w_issue = bus.md_valid && !bus.flush && !r_busy && (bus.md_func != 3'b000);

  // Full-width product, selected by the sign latched at issue.
  assign w_prod_s = $signed({{32{r_op_a[31]}}, r_op_a}) * $signed({{32{r_op_b[31]}}, r_op_b});
  assign w_prod_u = {32'b0, r_op_a} * {32'b0, r_op_b};
  assign w_prod   = r_sign ? w_prod_s : w_prod_u;

  // One restoring divide step: shift in the next dividend bit, trial-subtract divisor.
  assign w_rem_sh = {r_rem, r_op_a[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_op_b};
  assign w_ge     = !w_diff[32];

  // Sign fix-up; remainder follows the dividend, so a zero divisor yields rs as latched.
  assign w_quot = r_neg_q ? 32'(-r_op_a) : r_op_a;
  assign w_remd = r_neg_r ? 32'(-r_rem) : r_rem;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_rem      <= '0;
      r_sign     <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_issue) begin
              case (bus.md_func)
                F_MULT: begin
                  r_state <= S_MUL;
                  r_busy  <= 1'b1;
                  r_cnt   <= CNT_W'(MUL_LAT - 1);
                  r_op_a  <= bus.rs_val;
                  r_op_b  <= bus.rt_val;
                  r_sign  <= bus.md_sign;
                end
                F_DIV: begin
                  r_state    <= S_DIV;
                  r_busy     <= 1'b1;
                  r_cnt      <= CNT_W'(DIV_ITER - 1);
                  r_op_a     <= (bus.md_sign && bus.rs_val[31]) ? 32'(-bus.rs_val) : bus.rs_val;
                  r_op_b     <= (bus.md_sign && bus.rt_val[31]) ? 32'(-bus.rt_val) : bus.rt_val;
                  r_rem      <= '0;
                  r_neg_q    <= bus.md_sign && (bus.rs_val[31] ^ bus.rt_val[31]);
                  r_neg_r    <= bus.md_sign && bus.rs_val[31];
                  r_div_zero <= (bus.rt_val == 32'b0);
                end
                F_MTHI:  r_hi <= bus.rs_val;
                F_MTLO:  r_lo <= bus.rs_val;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            if (r_cnt == '0) begin
              r_hi    <= w_prod[63:32];
              r_lo    <= w_prod[31:0];
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_DIV: begin
            r_rem  <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
            r_op_a <= {r_op_a[30:0], w_ge};
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_FIX: begin
            r_lo    <= r_div_zero ? 32'hFFFF_FFFF : w_quot;
            r_hi    <= w_remd;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, corner sequences, random vs model.
module tb_md_unit;

  localparam int unsigned MUL_LAT  = 4;
  localparam int unsigned DIV_ITER = 32;

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;

  typedef struct {
    logic [2:0]  func;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  md_unit_if bus ();

  md_unit #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  task automatic model(input logic [2:0] f, input logic s, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    longint sa, sb, q, r;
    if (f == F_MULT) begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'b0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      el = 32'(q);
      eh = 32'(r);
    end else begin
      el = a / b;
      eh = a % b;
    end
  endtask

  task automatic drive_idle();
    bus.md_valid = 1'b0;
    bus.md_func  = 3'b000;
    bus.md_sign  = 1'b0;
    bus.flush    = 1'b0;
    bus.rs_val   = 32'b0;
    bus.rt_val   = 32'b0;
  endtask

  // Issue a MULT/DIV, count busy cycles until done, then check result and latency.
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input string nm);
    int  n_busy;
    bit  seen;
    int  lat;
    lat = (f == F_MULT) ? int'(MUL_LAT) : int'(DIV_ITER) + 1;
    @(negedge clk);
    bus.md_valid = 1'b1;
    bus.md_func  = f;
    bus.md_sign  = s;
    bus.rs_val   = a;
    bus.rt_val   = b;
    @(negedge clk);
    drive_idle();
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) n_busy++;
      @(negedge clk);
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " busy_cycles"}, 32'(n_busy), 32'(lat));
    chk({nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({nm, " hi"}, bus.hi, eh);
    chk({nm, " lo"}, bus.lo, el);
  endtask

  // Issue an MTHI/MTLO (optionally with flush) and return one cycle later.
  task automatic run_mt(input logic [2:0] f, input logic [31:0] a, input logic fl);
    @(negedge clk);
    bus.md_valid = 1'b1;
    bus.md_func  = f;
    bus.rs_val   = a;
    bus.flush    = fl;
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] eh, el;
    logic [2:0]  f;
    logic        s;
    logic [31:0] a, b;
    bit          done_seen;

    vecs[0] = '{F_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3"};
    vecs[1] = '{F_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[2] = '{F_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
    vecs[3] = '{F_DIV,  1'b0, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, "divu_by0"};
    vecs[4] = '{F_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "div_ovf"};
    vecs[5] = '{F_DIV,  1'b0, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7"};
    vecs[6] = '{F_MULT, 1'b1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7xm1"};
    vecs[7] = '{F_DIV,  1'b1, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7_by0"};

    drive_idle();
    #12;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i])
      run_op(vecs[i].func, vecs[i].sign, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

    // MTHI / MTLO preload, visible one cycle after issue
    run_mt(F_MTHI, 32'h1234, 1'b0);
    chk("mthi hi", bus.hi, 32'h1234);
    chk("mthi busy", 32'(bus.busy), 32'd0);
    run_mt(F_MTLO, 32'h5678, 1'b0);
    chk("mtlo lo", bus.lo, 32'h5678);

    // DIV flushed at its tenth busy cycle: no done, HI/LO untouched
    @(negedge clk);
    bus.md_valid = 1'b1;
    bus.md_func  = F_DIV;
    bus.md_sign  = 1'b1;
    bus.rs_val   = 32'd1000;
    bus.rt_val   = 32'd3;
    @(negedge clk);
    drive_idle();
    done_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (bus.done) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("flush pre busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy_drop", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("flush no_done", 32'(done_seen), 32'd0);
    chk("flush hi", bus.hi, 32'h1234);
    chk("flush lo", bus.lo, 32'h5678);

    // Flush in the MTLO issue cycle blocks the write
    run_mt(F_MTLO, 32'hDEAD_BEEF, 1'b1);
    chk("flush_mt lo", bus.lo, 32'h5678);

    // Flush in a MULT issue cycle blocks the issue
    run_mt(F_MULT, 32'd5, 1'b1);
    chk("flush_issue busy", 32'(bus.busy), 32'd0);

    // Async reset mid-MULT
    @(negedge clk);
    bus.md_valid = 1'b1;
    bus.md_func  = F_MULT;
    bus.md_sign  = 1'b0;
    bus.rs_val   = 32'd9;
    bus.rt_val   = 32'd9;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    chk("arst hi", bus.hi, 32'd0);
    chk("arst lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("arst no_done", 32'(bus.done), 32'd0);

    // Randomized ops vs reference model
    for (int k = 0; k < 40; k++) begin
      f = ($urandom_range(0, 1) == 0) ? F_MULT : F_DIV;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 5));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      model(f, s, a, b, eh, el);
      run_op(f, s, a, b, eh, el, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the EX stage of the five-stage MIPS pipeline. Consumes the EX-stage MD control fields (function, sign) and forwarded rs/rt operands, and owns the architectural HI/LO registers read by MFHI/MFLO. Exports `busy` to stall detection, which holds any MD-dependent instruction in ID until the result commits.

## Interface
Parameters:
- MUL_LAT, 4, cycles `busy` stays high for MULT/MULTU (≥1).
- DIV_ITER, 32, quotient bits per divide; the divide takes DIV_ITER+1 busy cycles.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- md_valid  in  1  EX holds a live MD instruction this cycle.
- md_func  in  3  000 none, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO; others treated as none.
- md_sign  in  1  1 signed (MULT/DIV), 0 unsigned (MULTU/DIVU).
- flush  in  1  EX flush; kills the issue or the in-flight operation.
- rs_val  in  32  forwarded rs (multiplicand/dividend/MT source).
- rt_val  in  32  forwarded rt (multiplier/divisor).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO take a MULT/DIV result.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

## Operation
- Issue: `md_valid && !flush && !busy && md_func!=000`. Issue while busy is ignored; stall logic prevents it.
- States: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on MULT issue.
  - IDLE→DIV on DIV issue.
  - MUL→IDLE after MUL_LAT cycles.
  - DIV→FIX after DIV_ITER iterations.
  - FIX→IDLE after 1 cycle.
  - Any state→IDLE on flush.
- MTHI/MTLO: write rs_val into hi/lo at the issuing clock edge. The state stays IDLE and `busy` stays low.
- MULT: latch the operands at issue. Produce the 64-bit product: signed when md_sign=1, otherwise unsigned. At completion, hi=product[63:32] and lo=product[31:0].
- DIV: latch operands at issue.
  - Signed: record the signs and divide magnitudes with a restoring shift/subtract, one quotient bit per cycle, 33-bit partial remainder.
  - FIX applies the signs: quotient negated if the signs differ, remainder takes the dividend's sign.
  - At completion, lo=quotient and hi=remainder.
- Divide by zero: full latency, lo=32'hFFFF_FFFF, hi=rs_val as latched.
- Signed 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Flush mid-operation: return to IDLE next edge. hi/lo keep their pre-issue values and no `done` pulse occurs.
- Flush in the issue cycle: no issue, no MT write.
- hi/lo change only on MT writes and `done`.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal operand/remainder registers=0.
- Issue accepted at edge T: busy=1 from T through the completing edge.
  - MULT: busy high for MUL_LAT cycles; done=1 and new hi/lo are visible in cycle T+MUL_LAT. busy=0 in that same cycle.
  - DIV: busy high for DIV_ITER+1 = 33 cycles; done and the result follow in cycle T+33.
- A new issue is legal in the cycle where done=1.
- MTHI/MTLO: new value visible the cycle after the issue edge (latency 1).
- busy and done are registered outputs with no combinational path from the inputs.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded.

## Test plan
- Reset, then signed MULT rs=0xFFFF_FFFE (-2), rt=3 → done at T+4, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, busy high exactly 4 cycles.
- MULTU 0xFFFF_FFFF×0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- Signed DIV -7/2 → after 33 busy cycles lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- DIVU 100/0 → lo=0xFFFF_FFFF, hi=100.
- Signed DIV 0x8000_0000/-1 → lo=0x8000_0000, hi=0.
- Preload via MTHI 0x1234 and MTLO 0x5678, then issue DIV and assert flush at cycle 10 → busy drops next cycle, no done, hi=0x1234, lo=0x5678.
- Flush in the same cycle as an MTLO issue → lo unchanged.
- Async reset pulse during a MULT → all outputs 0 immediately.
